// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 4-bit ALU: queues commands, issues one at a time, returns results; ALU_DIVZERO_FLAG_EN adds res_divz.
// Latency: accept at edge N, issue at N+1, result valid from N+2; one result per 2 cycles when streaming.
// Backpressure: cmd_ready = !fifo_full (registered); a result is held stable until res_ready.

module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_nxt = count - CW'(1);
    end
  end

  // Flags are registered so the ready seen upstream never depends on this cycle's pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];

endmodule

module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_opcode,
  input  logic [1:0] cmd_logic_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_opcode,
  output logic [1:0] alu_logic_sel,
  input  logic [7:0] alu_result,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [2:0] res_opcode,
  output logic       res_divz,
  output logic [7:0] op_count
);
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] opcode;
    logic [1:0] logic_sel;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state;
  cmd_t   push_cmd;
  cmd_t   head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;

  assign push_cmd  = '{a: cmd_a, b: cmd_b, opcode: cmd_opcode, logic_sel: cmd_logic_sel};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  // Issue from IDLE, or from DONE in the same edge the current result is taken.
  assign pop = !fifo_empty &&
               ((state == IDLE) || ((state == DONE) && res_valid && res_ready));

  cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_cmd),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_opcode    <= '0;
      alu_logic_sel <= '0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_opcode    <= '0;
      op_count      <= '0;
`ifdef ALU_DIVZERO_FLAG_EN
      res_divz      <= 1'b0;
`endif
    end else begin
      if (pop) begin
        alu_a         <= head.a;
        alu_b         <= head.b;
        alu_opcode    <= head.opcode;
        alu_logic_sel <= head.logic_sel;
      end
      case (state)
        IDLE: begin
          if (pop) state <= EXEC;
        end
        EXEC: begin
          res_data   <= alu_result;
          res_opcode <= alu_opcode;
          res_valid  <= 1'b1;
`ifdef ALU_DIVZERO_FLAG_EN
          res_divz   <= ((alu_opcode == 3'b011) || (alu_opcode == 3'b111)) && (alu_b == 4'h0);
`endif
          state      <= DONE;
        end
        DONE: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state     <= pop ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ALU_DIVZERO_FLAG_EN
  assign res_divz = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU stub on the alu_* side.
// Opcode map of the stub: 000 add, 001 sub, 010 logic, 011 div, 100 mul, 111 mod.

module tb_alu_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_opcode;
  logic [1:0] cmd_logic_sel;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opcode;
  logic [1:0] alu_logic_sel;
  logic [7:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_opcode;
  logic       res_divz;
  logic [7:0] op_count;

  int n_pass  = 0;
  int n_total = 0;

`ifdef ALU_DIVZERO_FLAG_EN
  localparam logic EXP_DZ = 1'b1;
`else
  localparam logic EXP_DZ = 1'b0;
`endif

  alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_opcode    (cmd_opcode),
    .cmd_logic_sel (cmd_logic_sel),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_opcode    (alu_opcode),
    .alu_logic_sel (alu_logic_sel),
    .alu_result    (alu_result),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_opcode    (res_opcode),
    .res_divz      (res_divz),
    .op_count      (op_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 8'h00;
    case (alu_opcode)
      3'b000: alu_result = {4'h0, alu_a} + {4'h0, alu_b};
      3'b001: alu_result = {4'h0, alu_a} - {4'h0, alu_b};
      3'b010: begin
        case (alu_logic_sel)
          2'b00:   alu_result = {4'h0, alu_a & alu_b};
          2'b01:   alu_result = {4'h0, alu_a | alu_b};
          2'b10:   alu_result = {4'h0, alu_a ^ alu_b};
          default: alu_result = {4'h0, ~alu_a};
        endcase
      end
      3'b011: alu_result = (alu_b == 4'h0) ? 8'hFF : {4'h0, alu_a / alu_b};
      3'b100: alu_result = {4'h0, alu_a} * {4'h0, alu_b};
      3'b111: alu_result = (alu_b == 4'h0) ? 8'hFF : {4'h0, alu_a % alu_b};
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                      input logic [1:0] sel, output logic acc);
    cmd_a         = a;
    cmd_b         = b;
    cmd_opcode    = op;
    cmd_logic_sel = sel;
    cmd_valid     = 1'b1;
    acc           = cmd_ready;
    tick();
    cmd_valid     = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, res_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       acc;
    int         acc_cnt;
    logic       seen;
    logic [7:0] exp_data [5];
    logic [2:0] exp_op   [5];

    exp_data = '{8'h03, 8'h02, 8'h06, 8'h04, 8'h2A};
    exp_op   = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};

    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_opcode = '0; cmd_logic_sel = '0;
    res_ready = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_divz",  res_divz,  0);
    chk("rst_res_data",  res_data,  0);
    chk("rst_alu_a",     alu_a,     0);
    chk("rst_op_count",  op_count,  0);
    rst = 1'b0;

    // Reset with a result in flight and three commands queued.
    push(4'd2, 4'd3, 3'b000, 2'b00, acc);
    push(4'd1, 4'd1, 3'b000, 2'b00, acc);
    push(4'd4, 4'd4, 3'b000, 2'b00, acc);
    push(4'd9, 4'd9, 3'b000, 2'b00, acc);
    chk("midrst_pre_valid", res_valid, 1);
    chk("midrst_pre_data",  res_data,  8'h05);
    #3 rst = 1'b1;
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_data",  res_data,  0);
    chk("midrst_alu_a",     alu_a,     0);
    chk("midrst_alu_b",     alu_b,     0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    tick();
    rst       = 1'b0;
    res_ready = 1'b1;
    seen      = 1'b0;
    repeat (8) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("postrst_no_result", seen,      0);
    chk("postrst_cmd_ready", cmd_ready, 1);
    chk("postrst_alu_a",     alu_a,     0);
    chk("postrst_op_count",  op_count,  0);

    // Single add 9+7.
    push(4'd9, 4'd7, 3'b000, 2'b00, acc);
    chk("add_accepted",   acc,       1);
    chk("add_n_valid",    res_valid, 0);
    tick();
    chk("add_n1_opcode",  alu_opcode, 3'b000);
    chk("add_n1_alu_a",   alu_a,      4'd9);
    chk("add_n1_alu_b",   alu_b,      4'd7);
    chk("add_n1_valid",   res_valid,  0);
    tick();
    chk("add_n2_valid",   res_valid,  1);
    chk("add_n2_data",    res_data,   8'h10);
    chk("add_n2_opcode",  res_opcode, 3'b000);
    chk("add_n2_count",   op_count,   0);
    tick();
    chk("add_hs_valid",   res_valid,  0);
    chk("add_hs_count",   op_count,   1);

    // Back-to-back mul 15*15 then add 3+4.
    push(4'd15, 4'd15, 3'b100, 2'b00, acc);
    push(4'd3,  4'd4,  3'b000, 2'b00, acc);
    tick();
    chk("b2b_1_valid",  res_valid,  1);
    chk("b2b_1_data",   res_data,   8'hE1);
    chk("b2b_1_opcode", res_opcode, 3'b100);
    tick();
    chk("b2b_gap_valid", res_valid, 0);
    chk("b2b_gap_count", op_count,  2);
    tick();
    chk("b2b_2_valid",  res_valid,  1);
    chk("b2b_2_data",   res_data,   8'h07);
    tick();
    chk("b2b_end_count", op_count,  3);

    // Backpressure: five fit (four queued plus one in flight), the sixth is refused.
    res_ready = 1'b0;
    acc_cnt   = 0;
    push(4'd1,  4'd2,  3'b000, 2'b00, acc); acc_cnt += int'(acc);
    push(4'd5,  4'd3,  3'b001, 2'b00, acc); acc_cnt += int'(acc);
    push(4'd12, 4'd10, 3'b010, 2'b10, acc); acc_cnt += int'(acc);
    push(4'd8,  4'd2,  3'b011, 2'b00, acc); acc_cnt += int'(acc);
    push(4'd6,  4'd7,  3'b100, 2'b00, acc); acc_cnt += int'(acc);
    chk("full_five_accepted", acc_cnt, 5);
    push(4'd1,  4'd1,  3'b000, 2'b00, acc);
    chk("full_sixth_refused", acc,       0);
    chk("full_cmd_ready",     cmd_ready, 0);
    repeat (3) tick();
    chk("hold_valid",  res_valid,  1);
    chk("hold_data",   res_data,   8'h03);
    chk("hold_opcode", res_opcode, 3'b000);
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid("drain");
      chk("drain_data",   res_data,   exp_data[i]);
      chk("drain_opcode", res_opcode, exp_op[i]);
      tick();
    end
    repeat (3) tick();
    chk("drain_cmd_ready", cmd_ready, 1);
    chk("drain_valid",     res_valid, 0);
    chk("drain_count",     op_count,  8);

    // Division by zero, then a normal division.
    push(4'd12, 4'd0, 3'b011, 2'b00, acc);
    wait_valid("divz");
    chk("divz_flag",   res_divz,   EXP_DZ);
    chk("divz_opcode", res_opcode, 3'b011);
    chk("divz_data",   res_data,   8'hFF);
    tick();
    push(4'd12, 4'd3, 3'b011, 2'b00, acc);
    wait_valid("div");
    chk("div_flag",  res_divz, 0);
    chk("div_data",  res_data, 8'h04);
    tick();
    chk("div_count", op_count, 10);

    // 246 more operations bring the total to 256, so the counter wraps to 0.
    acc_cnt = 0;
    for (int i = 0; i < 246; i++) begin
      push(4'd1, 4'd1, 3'b000, 2'b00, acc);
      acc_cnt += int'(acc);
      tick();
    end
    repeat (6) tick();
    chk("wrap_accepted", acc_cnt,   246);
    chk("wrap_count",    op_count,  0);
    chk("wrap_data",     res_data,  8'h02);
    chk("wrap_valid",    res_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
